// File: rtl/regbank_8088_read_port_pkg.sv
// Shared definitions for the 8088 register bank: address encoding, read FSM
// states, SP reset default and the high-byte write lane helper.
package regbank_8088_pkg;

  // 4-bit register address encoding, shared by the read and write sides
  localparam logic [3:0] DIR_AL = 4'b0000;
  localparam logic [3:0] DIR_CL = 4'b0001;
  localparam logic [3:0] DIR_DL = 4'b0010;
  localparam logic [3:0] DIR_BL = 4'b0011;
  localparam logic [3:0] DIR_AH = 4'b0100;
  localparam logic [3:0] DIR_CH = 4'b0101;
  localparam logic [3:0] DIR_DH = 4'b0110;
  localparam logic [3:0] DIR_BH = 4'b0111;
  localparam logic [3:0] DIR_AX = 4'b1000;
  localparam logic [3:0] DIR_CX = 4'b1001;
  localparam logic [3:0] DIR_DX = 4'b1010;
  localparam logic [3:0] DIR_BX = 4'b1011;
  localparam logic [3:0] DIR_SP = 4'b1100;
  localparam logic [3:0] DIR_BP = 4'b1101;
  localparam logic [3:0] DIR_SI = 4'b1110;
  localparam logic [3:0] DIR_DI = 4'b1111;

  localparam logic [15:0] SP_INIT_DEFAULT = 16'h0000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } rd_state_e;

  // Value written to a high byte: the upper lane when the whole pair is
  // written, otherwise the 8-bit operand that travels on the low lane.
  function automatic logic [7:0] hi_byte_data(input logic lo_en, input logic [15:0] wdata);
    hi_byte_data = lo_en ? wdata[15:8] : wdata[7:0];
  endfunction

endpackage

// File: rtl/regbank_8088_read_port_rd_mux.sv
// Combinational read selector: maps a 4-bit register address onto the
// twelve stored bytes/words and zero-extends the 8-bit views.
module regbank_rd_mux
  import regbank_8088_pkg::*;
(
  input  logic [3:0]  dir_i,
  input  logic [7:0]  al_i,
  input  logic [7:0]  ah_i,
  input  logic [7:0]  bl_i,
  input  logic [7:0]  bh_i,
  input  logic [7:0]  cl_i,
  input  logic [7:0]  ch_i,
  input  logic [7:0]  dl_i,
  input  logic [7:0]  dh_i,
  input  logic [15:0] sp_i,
  input  logic [15:0] bp_i,
  input  logic [15:0] si_i,
  input  logic [15:0] di_i,
  output logic [15:0] rd_val_o
);

  // Select the addressed view
  always_comb begin
    rd_val_o = 16'h0000;
    case (dir_i)
      DIR_AL:  rd_val_o = {8'h00, al_i};
      DIR_CL:  rd_val_o = {8'h00, cl_i};
      DIR_DL:  rd_val_o = {8'h00, dl_i};
      DIR_BL:  rd_val_o = {8'h00, bl_i};
      DIR_AH:  rd_val_o = {8'h00, ah_i};
      DIR_CH:  rd_val_o = {8'h00, ch_i};
      DIR_DH:  rd_val_o = {8'h00, dh_i};
      DIR_BH:  rd_val_o = {8'h00, bh_i};
      DIR_AX:  rd_val_o = {ah_i, al_i};
      DIR_CX:  rd_val_o = {ch_i, cl_i};
      DIR_DX:  rd_val_o = {dh_i, dl_i};
      DIR_BX:  rd_val_o = {bh_i, bl_i};
      DIR_SP:  rd_val_o = sp_i;
      DIR_BP:  rd_val_o = bp_i;
      DIR_SI:  rd_val_o = si_i;
      DIR_DI:  rd_val_o = di_i;
      default: rd_val_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/regbank_8088_read_port.sv
// 8088 register bank storage plus a four-phase req/ack read port.
// Optional feature: define REGBANK_RD_FWD_EN to forward a write committing
// on the read-acceptance edge into the captured read data.
module regbank_8088_read_port
  import regbank_8088_pkg::*;
#(
  parameter logic [15:0] SP_INIT = SP_INIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WAL,
  input  logic        WAH,
  input  logic        WBL,
  input  logic        WBH,
  input  logic        WCL,
  input  logic        WCH,
  input  logic        WDL,
  input  logic        WDH,
  input  logic        WSP,
  input  logic        WBP,
  input  logic        WSI,
  input  logic        WDI,
  input  logic [15:0] WData,
  input  logic        rd_req,
  input  logic [3:0]  rd_dir,
  output logic        rd_ack,
  output logic [15:0] rd_data
);

  logic [7:0]  al_q, ah_q, bl_q, bh_q, cl_q, ch_q, dl_q, dh_q;
  logic [7:0]  al_d, ah_d, bl_d, bh_d, cl_d, ch_d, dl_d, dh_d;
  logic [15:0] sp_q, bp_q, si_q, di_q;
  logic [15:0] sp_d, bp_d, si_d, di_d;

  rd_state_e   state_q, state_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [15:0] mux_val;

  // Next register contents: every asserted enable applies independently
  always_comb begin
    al_d = WAL ? WData[7:0] : al_q;
    bl_d = WBL ? WData[7:0] : bl_q;
    cl_d = WCL ? WData[7:0] : cl_q;
    dl_d = WDL ? WData[7:0] : dl_q;
    ah_d = WAH ? hi_byte_data(WAL, WData) : ah_q;
    bh_d = WBH ? hi_byte_data(WBL, WData) : bh_q;
    ch_d = WCH ? hi_byte_data(WCL, WData) : ch_q;
    dh_d = WDH ? hi_byte_data(WDL, WData) : dh_q;
    sp_d = WSP ? WData : sp_q;
    bp_d = WBP ? WData : bp_q;
    si_d = WSI ? WData : si_q;
    di_d = WDI ? WData : di_q;
  end

  // Register storage; writes commit every edge regardless of the read FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_q <= 8'h00; ah_q <= 8'h00; bl_q <= 8'h00; bh_q <= 8'h00;
      cl_q <= 8'h00; ch_q <= 8'h00; dl_q <= 8'h00; dh_q <= 8'h00;
      sp_q <= SP_INIT;
      bp_q <= 16'h0000;
      si_q <= 16'h0000;
      di_q <= 16'h0000;
    end else begin
      al_q <= al_d; ah_q <= ah_d; bl_q <= bl_d; bh_q <= bh_d;
      cl_q <= cl_d; ch_q <= ch_d; dl_q <= dl_d; dh_q <= dh_d;
      sp_q <= sp_d;
      bp_q <= bp_d;
      si_q <= si_d;
      di_q <= di_d;
    end
  end

`ifdef REGBANK_RD_FWD_EN
  // Next-state view: bytes written this edge are forwarded, the rest equal storage
  regbank_rd_mux u_rd_mux (
    .dir_i   (rd_dir),
    .al_i    (al_d), .ah_i (ah_d), .bl_i (bl_d), .bh_i (bh_d),
    .cl_i    (cl_d), .ch_i (ch_d), .dl_i (dl_d), .dh_i (dh_d),
    .sp_i    (sp_d), .bp_i (bp_d), .si_i (si_d), .di_i (di_d),
    .rd_val_o(mux_val)
  );
`else
  // Storage view only: a write on the acceptance edge is not visible
  regbank_rd_mux u_rd_mux (
    .dir_i   (rd_dir),
    .al_i    (al_q), .ah_i (ah_q), .bl_i (bl_q), .bh_i (bh_q),
    .cl_i    (cl_q), .ch_i (ch_q), .dl_i (dl_q), .dh_i (dh_q),
    .sp_i    (sp_q), .bp_i (bp_q), .si_i (si_q), .di_i (di_q),
    .rd_val_o(mux_val)
  );
`endif

  // Read handshake next state; data is snapshotted only on acceptance
  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          state_d   = ST_ACK;
          rd_data_d = mux_val;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (rd_req) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rd_data_d = 16'h0000;
      end
    endcase
  end

  // Read FSM state and captured data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_data_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_ack  = (state_q == ST_ACK);
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_regbank_8088_read_port.sv
// Self-checking bench for regbank_8088_read_port: table-driven write/read
// vectors, hand-written handshake/reset sequences, and randomized traffic
// against a word-level model of the eight 16-bit registers.
module tb_regbank_8088_read_port;

  localparam logic [15:0] SPI = 16'hFFFE;

  localparam logic [11:0] E_NONE = 12'h000;
  localparam logic [11:0] E_AL = 12'h800, E_AH = 12'h400;
  localparam logic [11:0] E_BL = 12'h200, E_BH = 12'h100;
  localparam logic [11:0] E_CL = 12'h080, E_CH = 12'h040;
  localparam logic [11:0] E_DL = 12'h020, E_DH = 12'h010;
  localparam logic [11:0] E_SP = 12'h008, E_BP = 12'h004;
  localparam logic [11:0] E_SI = 12'h002, E_DI = 12'h001;

`ifdef REGBANK_RD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        WAL, WAH, WBL, WBH, WCL, WCH, WDL, WDH, WSP, WBP, WSI, WDI;
  logic [15:0] WData = 16'h0000;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_dir = 4'h0;
  logic        rd_ack;
  logic [15:0] rd_data;

  int errors = 0;
  int checks = 0;

  // Model: 0 AX, 1 CX, 2 DX, 3 BX, 4 SP, 5 BP, 6 SI, 7 DI
  logic [15:0] m_word [8];

  regbank_8088_read_port #(.SP_INIT(SPI)) dut (
    .clk(clk), .rst_n(rst_n),
    .WAL(WAL), .WAH(WAH), .WBL(WBL), .WBH(WBH),
    .WCL(WCL), .WCH(WCH), .WDL(WDL), .WDH(WDH),
    .WSP(WSP), .WBP(WBP), .WSI(WSI), .WDI(WDI),
    .WData(WData), .rd_req(rd_req), .rd_dir(rd_dir),
    .rd_ack(rd_ack), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_en(input logic [11:0] en);
    {WAL, WAH, WBL, WBH, WCL, WCH, WDL, WDH, WSP, WBP, WSI, WDI} = en;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_word[i] = 16'h0000;
    m_word[4] = SPI;
  endtask

  function automatic logic [15:0] m_read(input logic [3:0] d);
    logic [15:0] w;
    if (!d[3]) begin
      w = m_word[{1'b0, d[1:0]}];
      return d[2] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
    end
    return m_word[d[2:0]];
  endfunction

  task automatic m_write(input logic [11:0] en, input logic [15:0] data);
    // pair order in the enable vector: A, B, C, D; model word order A, C, D, B
    int widx [4];
    widx[0] = 0; widx[1] = 3; widx[2] = 1; widx[3] = 2;
    for (int p = 0; p < 4; p++) begin
      logic lo, hi;
      lo = en[11 - 2*p];
      hi = en[10 - 2*p];
      if (lo) m_word[widx[p]][7:0] = data[7:0];
      if (hi) m_word[widx[p]][15:8] = lo ? data[15:8] : data[7:0];
    end
    for (int k = 0; k < 4; k++)
      if (en[3 - k]) m_word[4 + k] = data;
  endtask

  // Starts and ends at a negedge
  task automatic do_write(input logic [11:0] en, input logic [15:0] data);
    set_en(en);
    WData = data;
    @(negedge clk);
    set_en(E_NONE);
    m_write(en, data);
  endtask

  // Full handshake; starts and ends at a negedge
  task automatic do_read(input string name, input logic [3:0] d, output logic [15:0] val);
    int n;
    rd_req = 1'b1;
    rd_dir = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_ack && n < 8);
    check({name, "_ack"}, {15'h0, rd_ack}, 16'h0001);
    val = rd_data;
    rd_req = 1'b0;
    @(negedge clk);
    check({name, "_ackdrop"}, {15'h0, rd_ack}, 16'h0000);
  endtask

  typedef struct {
    string       name;
    logic [11:0] en;
    logic [15:0] wdata;
    logic [3:0]  dir;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [15:0] v, exp_v, hold_v;
    logic [11:0] ren;
    logic [15:0] rdat;
    logic [3:0]  rdir;

    set_en(E_NONE);
    m_reset();

    vecs[0]  = '{"rst_sp",  E_NONE,      16'h0000, 4'b1100, 16'hFFFE};
    vecs[1]  = '{"rst_ax",  E_NONE,      16'h0000, 4'b1000, 16'h0000};
    vecs[2]  = '{"ax_full", E_AL | E_AH, 16'h1234, 4'b1000, 16'h1234};
    vecs[3]  = '{"ah_view", E_NONE,      16'h0000, 4'b0100, 16'h0012};
    vecs[4]  = '{"al_view", E_NONE,      16'h0000, 4'b0000, 16'h0034};
    vecs[5]  = '{"cx_hi",   E_CH,        16'h00AB, 4'b1001, 16'hAB00};
    vecs[6]  = '{"ch_view", E_NONE,      16'h0000, 4'b0101, 16'h00AB};
    vecs[7]  = '{"dx_hi",   E_DH,        16'h99C3, 4'b1010, 16'hC300};
    vecs[8]  = '{"dx_lo",   E_DL,        16'h8877, 4'b1010, 16'hC377};
    vecs[9]  = '{"sp_wr",   E_SP,        16'h0102, 4'b1100, 16'h0102};
    vecs[10] = '{"bh_mix",  E_BH | E_SI, 16'h4D21, 4'b0111, 16'h0021};
    vecs[11] = '{"si_mix",  E_NONE,      16'h0000, 4'b1110, 16'h4D21};

    // Reset state
    @(negedge clk);
    check("rst_ack0", {15'h0, rd_ack}, 16'h0000);
    rd_req = 1'b1;
    @(negedge clk);
    check("rst_ack1", {15'h0, rd_ack}, 16'h0000);
    check("rst_data", rd_data, 16'h0000);
    rd_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven writes then reads
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].en != E_NONE) do_write(vecs[i].en, vecs[i].wdata);
      do_read(vecs[i].name, vecs[i].dir, v);
      check(vecs[i].name, v, vecs[i].exp);
    end

    // Read DI while DI is written on the acceptance edge
    do_write(E_DI, 16'h1111);
    rd_req = 1'b1;
    rd_dir = 4'b1111;
    set_en(E_DI);
    WData = 16'h5555;
    @(negedge clk);
    set_en(E_NONE);
    m_write(E_DI, 16'h5555);
    check("di_same_edge_ack", {15'h0, rd_ack}, 16'h0001);
    check("di_same_edge", rd_data, FWD ? 16'h5555 : 16'h1111);
    rd_req = 1'b0;
    @(negedge clk);
    check("di_same_edge_drop", {15'h0, rd_ack}, 16'h0000);

    // Hold rd_req for 5 cycles, write BX=BEEF during ACK, wiggle rd_dir
    hold_v = m_read(4'b1011);
    rd_req = 1'b1;
    rd_dir = 4'b1011;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check("hold_ack", {15'h0, rd_ack}, 16'h0001);
      check("hold_data", rd_data, hold_v);
      rd_dir = 4'($urandom);
      if (c == 1) begin
        set_en(E_BL | E_BH);
        WData = 16'hBEEF;
      end else begin
        set_en(E_NONE);
      end
      @(negedge clk);
      if (c == 1) m_write(E_BL | E_BH, 16'hBEEF);
    end
    set_en(E_NONE);
    check("hold_data_end", rd_data, hold_v);
    rd_req = 1'b0;
    @(negedge clk);
    check("hold_drop", {15'h0, rd_ack}, 16'h0000);
    do_read("bx_after", 4'b1011, v);
    check("bx_after", v, 16'hBEEF);

    // Asynchronous reset in the middle of a handshake
    rd_req = 1'b1;
    rd_dir = 4'b1000;
    @(negedge clk);
    check("mid_rst_ack_before", {15'h0, rd_ack}, 16'h0001);
    check("mid_rst_data_before", rd_data, 16'h1234);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ack", {15'h0, rd_ack}, 16'h0000);
    check("mid_rst_data", rd_data, 16'h0000);
    rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    @(negedge clk);
    do_read("post_rst_sp", 4'b1100, v);
    check("post_rst_sp", v, SPI);
    do_read("post_rst_bx", 4'b1011, v);
    check("post_rst_bx", v, 16'h0000);

    // Randomized reads with concurrent random writes
    for (int it = 0; it < 200; it++) begin
      rdir = 4'($urandom);
      ren  = 12'($urandom) & 12'($urandom);
      rdat = 16'($urandom);
      rd_req = 1'b1;
      rd_dir = rdir;
      set_en(ren);
      WData = rdat;
      @(negedge clk);
      exp_v = m_read(rdir);
      m_write(ren, rdat);
      if (FWD) exp_v = m_read(rdir);
      check("rand_ack", {15'h0, rd_ack}, 16'h0001);
      check("rand_data", rd_data, exp_v);
      ren  = 12'($urandom) & 12'($urandom);
      rdat = 16'($urandom);
      rd_req = 1'b0;
      rd_dir = 4'($urandom);
      set_en(ren);
      WData = rdat;
      @(negedge clk);
      m_write(ren, rdat);
      set_en(E_NONE);
      check("rand_drop", {15'h0, rd_ack}, 16'h0000);
    end

    // Final sweep of all sixteen views against the model
    for (int d = 0; d < 16; d++) begin
      do_read("sweep", 4'(d), v);
      check("sweep", v, m_read(4'(d)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
